// File: rtl/pulse_channel_if.sv
// Pulse channel bus: configuration, frame tick and sample outputs.
// master drives the i_* signals (controller / bench); slave is the channel.
//   i_tick_stb     frame tick (envelope, length, sweep)
//   i_cfg_stb      latch configuration and retrigger the note
//   i_duty .. i_sweep_period  note configuration, sampled on i_cfg_stb
//   o_output       registered sample to the mixer
//   o_frame_pulse  phase MSB
//   o_active       length counter not expired
//   o_muted        sweep overflow or delta below the audible minimum
interface pulse_channel_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned VOL_W   = 4,
    parameter int unsigned OUT_W   = 9,
    parameter int unsigned LEN_W   = 8
);
    logic               i_tick_stb;
    logic               i_cfg_stb;
    logic [1:0]         i_duty;
    logic [VOL_W-1:0]   i_volume;
    logic               i_env_decay;
    logic               i_env_loop;
    logic [3:0]         i_env_period;
    logic [LEN_W-1:0]   i_length;
    logic               i_length_en;
    logic [PHASE_W-1:0] i_phase_delta;
    logic               i_sweep_en;
    logic               i_sweep_negate;
    logic [2:0]         i_sweep_shift;
    logic [3:0]         i_sweep_period;
    logic [OUT_W-1:0]   o_output;
    logic               o_frame_pulse;
    logic               o_active;
    logic               o_muted;

    modport master (
        output i_tick_stb, i_cfg_stb, i_duty, i_volume, i_env_decay, i_env_loop,
               i_env_period, i_length, i_length_en, i_phase_delta, i_sweep_en,
               i_sweep_negate, i_sweep_shift, i_sweep_period,
        input  o_output, o_frame_pulse, o_active, o_muted
    );

    modport slave (
        input  i_tick_stb, i_cfg_stb, i_duty, i_volume, i_env_decay, i_env_loop,
               i_env_period, i_length, i_length_en, i_phase_delta, i_sweep_en,
               i_sweep_negate, i_sweep_shift, i_sweep_period,
        output o_output, o_frame_pulse, o_active, o_muted
    );
endinterface

// File: rtl/pulse_channel.sv
// Pulse-wave voice: phase accumulator, 4-mode duty, decay envelope,
// length counter and frequency sweep. Retriggered by bus.i_cfg_stb,
// frame-rate updates on bus.i_tick_stb.
// Ports: i_clk, i_rst_n (async, active-low), bus (pulse_channel_if.slave).
module pulse_channel #(
    parameter int unsigned PHASE_W   = 32,
    parameter int unsigned VOL_W     = 4,
    parameter int unsigned OUT_W     = 9,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned MIN_DELTA = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pulse_channel_if.slave  bus
);
    localparam int unsigned SHIFT_W = OUT_W - VOL_W;

    // Latched note configuration
    logic [1:0]         duty_q,         duty_d;
    logic [VOL_W-1:0]   volume_q,       volume_d;
    logic               decay_q,        decay_d;
    logic               loop_q,         loop_d;
    logic [3:0]         env_period_q,   env_period_d;
    logic               length_en_q,    length_en_d;
    logic               sweep_en_q,     sweep_en_d;
    logic               negate_q,       negate_d;
    logic [2:0]         shift_q,        shift_d;
    logic [3:0]         sweep_period_q, sweep_period_d;

    // Running voice state
    logic [PHASE_W-1:0] phase,     phase_d;
    logic [PHASE_W-1:0] delta,     delta_d;
    logic [VOL_W-1:0]   level,     level_d;
    logic [3:0]         env_div,   env_div_d;
    logic [LEN_W-1:0]   len,       len_d;
    logic [3:0]         sweep_div, sweep_div_d;
    logic [OUT_W-1:0]   sample,    sample_d;

    logic [2:0]         p;
    logic               high;
    logic               active;
    logic               muted;
    logic [PHASE_W-1:0] delta_shr;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] target;

    // Sweep target; the subtract path can never go below zero
    always_comb begin
        delta_shr = delta >> shift_q;
        sum       = {1'b0, delta} + {1'b0, delta_shr};
        target    = negate_q ? (delta - delta_shr) : sum[PHASE_W-1:0];
    end

    // Status flags derived from registered state
    always_comb begin
        active = !length_en_q || (len != '0);
        muted  = (delta < PHASE_W'(MIN_DELTA)) ||
                 (sweep_en_q && !negate_q && (shift_q != 3'd0) && sum[PHASE_W]);
    end

    // Duty waveform from the top three phase bits
    always_comb begin
        p    = phase[PHASE_W-1 -: 3];
        high = 1'b0;
        case (duty_q)
            2'd0:    high = (p == 3'd0);
            2'd1:    high = (p < 3'd2);
            2'd2:    high = (p < 3'd4);
            default: high = (p < 3'd6);
        endcase
    end

    // Next-state: cfg retrigger takes priority and suppresses the tick
    always_comb begin
        duty_d         = duty_q;
        volume_d       = volume_q;
        decay_d        = decay_q;
        loop_d         = loop_q;
        env_period_d   = env_period_q;
        length_en_d    = length_en_q;
        sweep_en_d     = sweep_en_q;
        negate_d       = negate_q;
        shift_d        = shift_q;
        sweep_period_d = sweep_period_q;
        phase_d        = phase + delta;
        delta_d        = delta;
        level_d        = level;
        env_div_d      = env_div;
        len_d          = len;
        sweep_div_d    = sweep_div;
        sample_d       = (high && active && !muted) ? (OUT_W'(level) << SHIFT_W) : '0;

        if (bus.i_cfg_stb) begin
            duty_d         = bus.i_duty;
            volume_d       = bus.i_volume;
            decay_d        = bus.i_env_decay;
            loop_d         = bus.i_env_loop;
            env_period_d   = bus.i_env_period;
            length_en_d    = bus.i_length_en;
            sweep_en_d     = bus.i_sweep_en;
            negate_d       = bus.i_sweep_negate;
            shift_d        = bus.i_sweep_shift;
            sweep_period_d = bus.i_sweep_period;
            phase_d        = '0;
            delta_d        = bus.i_phase_delta;
            level_d        = bus.i_volume;
            env_div_d      = bus.i_env_period;
            len_d          = bus.i_length;
            sweep_div_d    = bus.i_sweep_period;
        end else if (bus.i_tick_stb) begin
            if (env_div == 4'd0) begin
                env_div_d = env_period_q;
                if (decay_q && (level != '0)) begin
                    level_d = level - VOL_W'(1);
                end else if (decay_q && loop_q) begin
                    level_d = volume_q;
                end
            end else begin
                env_div_d = env_div - 4'd1;
            end

            if (length_en_q && (len != '0)) begin
                len_d = len - LEN_W'(1);
            end

            // A muted channel keeps its delta frozen
            if (sweep_div == 4'd0) begin
                sweep_div_d = sweep_period_q;
                if (sweep_en_q && (shift_q != 3'd0) && !muted) begin
                    delta_d = target;
                end
            end else begin
                sweep_div_d = sweep_div - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            duty_q         <= '0;
            volume_q       <= '0;
            decay_q        <= 1'b0;
            loop_q         <= 1'b0;
            env_period_q   <= '0;
            length_en_q    <= 1'b0;
            sweep_en_q     <= 1'b0;
            negate_q       <= 1'b0;
            shift_q        <= '0;
            sweep_period_q <= '0;
            phase          <= '0;
            delta          <= '0;
            level          <= '0;
            env_div        <= '0;
            len            <= '0;
            sweep_div      <= '0;
            sample         <= '0;
        end else begin
            duty_q         <= duty_d;
            volume_q       <= volume_d;
            decay_q        <= decay_d;
            loop_q         <= loop_d;
            env_period_q   <= env_period_d;
            length_en_q    <= length_en_d;
            sweep_en_q     <= sweep_en_d;
            negate_q       <= negate_d;
            shift_q        <= shift_d;
            sweep_period_q <= sweep_period_d;
            phase          <= phase_d;
            delta          <= delta_d;
            level          <= level_d;
            env_div        <= env_div_d;
            len            <= len_d;
            sweep_div      <= sweep_div_d;
            sample         <= sample_d;
        end
    end

    assign bus.o_output      = sample;
    assign bus.o_frame_pulse = phase[PHASE_W-1];
    assign bus.o_active      = active;
    assign bus.o_muted       = muted;
endmodule

// File: tb/tb_pulse_channel.sv
// Directed bench for pulse_channel: reset state, duty patterns, envelope,
// length, sweep, cfg/tick collision and asynchronous reset mid-note.
module tb_pulse_channel;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned VOL_W   = 4;
    localparam int unsigned OUT_W   = 9;
    localparam int unsigned LEN_W   = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pulse_channel_if #(.PHASE_W(PHASE_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

    pulse_channel #(.PHASE_W(PHASE_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
                    .MIN_DELTA(256)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         duty;
        logic [VOL_W-1:0]   volume;
        logic               decay;
        logic               loop_en;
        logic [3:0]         env_period;
        logic [LEN_W-1:0]   length;
        logic               length_en;
        logic [PHASE_W-1:0] delta;
        logic               sweep_en;
        logic               negate;
        logic [2:0]         shift;
        logic [3:0]         sweep_period;
    } cfg_t;

    typedef struct {
        logic [1:0]  duty;
        int unsigned high_n;
    } duty_vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.duty = 2'd0; c.volume = 4'd15; c.decay = 1'b0; c.loop_en = 1'b0;
        c.env_period = 4'd0; c.length = '0; c.length_en = 1'b0;
        c.delta = 32'd256; c.sweep_en = 1'b0; c.negate = 1'b0;
        c.shift = 3'd0; c.sweep_period = 4'd0;
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c, input logic with_tick);
        bus.i_duty = c.duty; bus.i_volume = c.volume; bus.i_env_decay = c.decay;
        bus.i_env_loop = c.loop_en; bus.i_env_period = c.env_period;
        bus.i_length = c.length; bus.i_length_en = c.length_en;
        bus.i_phase_delta = c.delta; bus.i_sweep_en = c.sweep_en;
        bus.i_sweep_negate = c.negate; bus.i_sweep_shift = c.shift;
        bus.i_sweep_period = c.sweep_period;
        bus.i_cfg_stb = 1'b1;
        bus.i_tick_stb = with_tick;
        step();
        bus.i_cfg_stb = 1'b0;
        bus.i_tick_stb = 1'b0;
        // scramble config inputs: they must be ignored without the strobe
        bus.i_volume = 4'd7; bus.i_phase_delta = 32'hDEAD_BEEF; bus.i_duty = 2'd1;
    endtask

    // one tick, then one more clock so the registered sample reflects it
    task automatic frame_tick();
        bus.i_tick_stb = 1'b1;
        step();
        bus.i_tick_stb = 1'b0;
        step();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".output"}, 64'(bus.o_output), 64'd0);
        chk({name, ".muted"},  64'(bus.o_muted),  64'd1);
        chk({name, ".active"}, 64'(bus.o_active), 64'd1);
        chk({name, ".frame"},  64'(bus.o_frame_pulse), 64'd0);
    endtask

    initial begin
        duty_vec_t   duty_vecs [4];
        int          env_noloop [8];
        int          env_loop [8];
        logic [31:0] sweep_exp [8];
        logic        sweep_mute [8];
        cfg_t        c;
        logic        ok;

        duty_vecs[0] = '{duty: 2'd2, high_n: 8};
        duty_vecs[1] = '{duty: 2'd0, high_n: 2};
        duty_vecs[2] = '{duty: 2'd1, high_n: 4};
        duty_vecs[3] = '{duty: 2'd3, high_n: 12};
        env_noloop = '{3, 2, 2, 1, 1, 0, 0, 0};
        env_loop   = '{3, 2, 2, 1, 1, 0, 0, 3};
        sweep_exp  = '{32'h1800_0000, 32'h2400_0000, 32'h3600_0000, 32'h5100_0000,
                       32'h7980_0000, 32'hB640_0000, 32'hB640_0000, 32'hB640_0000};
        sweep_mute = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        bus.i_tick_stb = 1'b0; bus.i_cfg_stb = 1'b0;
        bus.i_duty = '0; bus.i_volume = '0; bus.i_env_decay = 1'b0; bus.i_env_loop = 1'b0;
        bus.i_env_period = '0; bus.i_length = '0; bus.i_length_en = 1'b0;
        bus.i_phase_delta = '0; bus.i_sweep_en = 1'b0; bus.i_sweep_negate = 1'b0;
        bus.i_sweep_shift = '0; bus.i_sweep_period = '0;
        repeat (3) step();
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;

        // idle after reset with ticks but no cfg: stays silent
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.i_tick_stb = (i % 10 == 0);
            step();
            if (bus.o_output !== '0 || bus.o_muted !== 1'b1 ||
                bus.o_active !== 1'b1 || bus.o_frame_pulse !== 1'b0) ok = 1'b0;
        end
        bus.i_tick_stb = 1'b0;
        chk("idle_100", 64'(ok), 64'd1);

        // duty patterns, 16-clock period starting one clock after strobe
        for (int v = 0; v < 4; v++) begin
            c = base_cfg();
            c.duty = duty_vecs[v].duty;
            c.delta = 32'h1000_0000;
            apply_cfg(c, 1'b0);
            for (int j = 0; j < 32; j++) begin
                step();
                chk($sformatf("duty%0d_cyc%0d", duty_vecs[v].duty, j), 64'(bus.o_output),
                    ((j % 16) < int'(duty_vecs[v].high_n)) ? 64'd480 : 64'd0);
            end
        end

        // envelope decay, without and with loop
        for (int lp = 0; lp < 2; lp++) begin
            c = base_cfg();
            c.volume = 4'd3; c.env_period = 4'd1; c.decay = 1'b1; c.loop_en = (lp == 1);
            apply_cfg(c, 1'b0);
            step();
            chk($sformatf("env%0d_start", lp), 64'(bus.o_output), 64'd96);
            for (int t = 0; t < 8; t++) begin
                frame_tick();
                chk($sformatf("env%0d_tick%0d", lp, t + 1), 64'(bus.o_output),
                    64'((lp == 1 ? env_loop[t] : env_noloop[t]) * 32));
            end
        end

        // length counter
        c = base_cfg();
        c.length = 8'd3; c.length_en = 1'b1;
        apply_cfg(c, 1'b0);
        for (int t = 0; t < 3; t++) begin
            frame_tick();
            chk($sformatf("len_active_t%0d", t + 1), 64'(bus.o_active), (t < 2) ? 64'd1 : 64'd0);
            chk($sformatf("len_out_t%0d", t + 1), 64'(bus.o_output), (t < 2) ? 64'd480 : 64'd0);
        end
        c.length_en = 1'b0;
        apply_cfg(c, 1'b0);
        repeat (5) frame_tick();
        chk("len_disabled_active", 64'(bus.o_active), 64'd1);
        chk("len_disabled_out", 64'(bus.o_output), 64'd480);

        // sweep up until carry mutes and freezes the delta
        c = base_cfg();
        c.duty = 2'd2; c.delta = 32'h1000_0000; c.sweep_en = 1'b1; c.shift = 3'd1;
        apply_cfg(c, 1'b0);
        chk("sweep_start_muted", 64'(bus.o_muted), 64'd0);
        for (int t = 0; t < 8; t++) begin
            frame_tick();
            chk($sformatf("sweep_delta_t%0d", t + 1), 64'(dut.delta), 64'(sweep_exp[t]));
            chk($sformatf("sweep_muted_t%0d", t + 1), 64'(bus.o_muted), 64'(sweep_mute[t]));
        end
        c.negate = 1'b1;
        apply_cfg(c, 1'b0);
        frame_tick();
        chk("sweep_negate", 64'(dut.delta), 64'h0800_0000);
        chk("sweep_negate_muted", 64'(bus.o_muted), 64'd0);

        // delta below MIN_DELTA mutes at once
        c = base_cfg();
        c.delta = 32'd100;
        apply_cfg(c, 1'b0);
        chk("min_delta_muted", 64'(bus.o_muted), 64'd1);
        step();
        chk("min_delta_out", 64'(bus.o_output), 64'd0);
        c.delta = 32'd255;
        apply_cfg(c, 1'b0);
        chk("delta255_muted", 64'(bus.o_muted), 64'd1);
        c.delta = 32'd256;
        apply_cfg(c, 1'b0);
        chk("delta256_muted", 64'(bus.o_muted), 64'd0);

        // cfg and tick together: no decrement of level or length
        c = base_cfg();
        c.volume = 4'd5; c.decay = 1'b1; c.env_period = 4'd0;
        c.length = 8'd1; c.length_en = 1'b1;
        apply_cfg(c, 1'b1);
        chk("coinc_active", 64'(bus.o_active), 64'd1);
        step();
        chk("coinc_out", 64'(bus.o_output), 64'd160);
        frame_tick();
        chk("coinc_after_tick_active", 64'(bus.o_active), 64'd0);

        // asynchronous reset mid-note
        c = base_cfg();
        c.duty = 2'd2; c.delta = 32'h1000_0000;
        apply_cfg(c, 1'b0);
        repeat (2) step();
        chk("pre_reset_out", 64'(bus.o_output), 64'd480);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk_reset_outputs("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
